// File: rtl/spi_tx_shiftreg16_if.sv
// spi_tx_shiftreg16_if: write handshake and serial output bundle for spi_tx_shiftreg16
interface spi_tx_shiftreg16_if #(parameter int WIDTH = 16);
    logic update;
    logic [WIDTH-1:0] din;
    logic wr_en;
    logic wr_ready;
    logic sdout;
    logic frame_en;
    logic busy;
    logic done;
    logic wr_ovf;
    modport master (
        output update, din, wr_en,
        input wr_ready, sdout, frame_en, busy, done, wr_ovf
    );
    modport slave (
        input update, din, wr_en,
        output wr_ready, sdout, frame_en, busy, done, wr_ovf
    );
endinterface

// File: rtl/spi_tx_shiftreg16.sv
// spi_tx_shiftreg16: buffered parallel-to-serial SPI transmit shift register
module spi_tx_shiftreg16 #(
    parameter int WIDTH = 16,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input logic clk,
    input logic rst,
    spi_tx_shiftreg16_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [0:0] state;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0] bit_cnt;
    logic hold_full;
    logic done_q;
    logic ovf_q;
    logic load;
    // refill from the holding buffer when idle, or on the last update of a frame
    assign load = hold_full && (state == IDLE || (bus.update && bit_cnt == LAST));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hold <= '0;
            hold_full <= 1'b0;
            shreg <= '0;
            bit_cnt <= '0;
            done_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ovf_q <= bus.wr_en && hold_full;
            if (bus.wr_en && !hold_full) begin
                hold <= bus.din;
                hold_full <= 1'b1;
            end
            if (load) begin
                shreg <= hold;
                hold_full <= 1'b0;
                bit_cnt <= '0;
                state <= SHIFT;
                done_q <= (state == SHIFT);
            end else if (state == SHIFT && bus.update) begin
                if (bit_cnt == LAST) begin
                    state <= IDLE;
                    shreg <= '0;
                    bit_cnt <= '0;
                    done_q <= 1'b1;
                end else begin
                    shreg <= MSB_FIRST ? shreg << 1 : shreg >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end
    assign bus.wr_ready = ~hold_full;
    assign bus.frame_en = (state == SHIFT);
    assign bus.busy = (state == SHIFT) | hold_full;
    assign bus.done = done_q;
    assign bus.wr_ovf = ovf_q;
    assign bus.sdout = (state == SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_LEVEL;
endmodule
